// File: rtl/lcd_pkg.sv
// Shared types and helpers for the LCD line writer: sweep state encoding,
// the blank character and the row/column address width helpers.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_WRITE  = 2'd2,
        ST_UPDATE = 2'd3
    } lcd_state_t;

    localparam logic [7:0] BLANK_CHAR = 8'h20;

    // Row address width; a single-row display still needs a 1-bit port.
    function automatic int lcd_rw(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    function automatic int lcd_clw(input int cols);
        return (cols > 1) ? $clog2(cols) : 1;
    endfunction

endpackage

// File: rtl/lcd_char_buf.sv
// ROWS x COLS character store: one synchronous write port, one
// combinational read port, every cell reset to the blank character.
module lcd_char_buf
    import lcd_pkg::*;
#(
    parameter int ROWS = 2,
    parameter int COLS = 16,
    parameter int CW   = 8,
    parameter int RW   = 1,
    parameter int CLW  = 4
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           we,
    input  logic [RW-1:0]  wr_row,
    input  logic [CLW-1:0] wr_col,
    input  logic [CW-1:0]  wr_data,
    input  logic [RW-1:0]  rd_row,
    input  logic [CLW-1:0] rd_col,
    output logic [CW-1:0]  rd_data
);

    localparam int CELLS = ROWS * COLS;
    localparam int AW    = $clog2(CELLS);
    localparam logic [CW-1:0] BLANK = CW'(BLANK_CHAR);

    logic [CW-1:0] mem [CELLS];
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;

    // Row-major flat addressing keeps the array index exactly AW bits wide.
    assign wr_addr = AW'(int'(wr_row) * COLS + int'(wr_col));
    assign rd_addr = AW'(int'(rd_row) * COLS + int'(rd_col));

    for (genvar a = 0; a < CELLS; a++) begin : g_cell
        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                mem[a] <= BLANK;
            end else if (we && (wr_addr == AW'(a))) begin
                mem[a] <= wr_data;
            end
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lcd_line_writer.sv
// Buffers character bursts per LCD row and sweeps the whole buffer out to
// the LCD driver on request. Optional macro LCD_BLANK_FILL_EN blanks cells
// beyond the length of each row's last burst.
module lcd_line_writer
    import lcd_pkg::*;
#(
    parameter int COLS = 16,
    parameter int ROWS = 2,
    parameter int CW   = 8,
    localparam int RW  = lcd_rw(ROWS),
    localparam int CLW = lcd_clw(COLS)
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           valid_i,
    input  logic [CW-1:0]  char_i,
    input  logic [RW-1:0]  row_sel_i,
    input  logic           start_update,
    input  logic           lcd_busy,
    output logic           lcd_we,
    output logic [RW-1:0]  lcd_row,
    output logic [CLW-1:0] lcd_col,
    output logic [CW-1:0]  lcd_char,
    output logic           update,
    output logic           ready_o
);

    // idx must reach COLS itself, so it is one state wider than a column.
    localparam int IW = $clog2(COLS + 1);

    lcd_state_t     state, state_nxt;
    logic           pending;
    logic [RW-1:0]  cur_row;
    logic [CLW-1:0] cur_col;
    logic           last_cell;
    logic           start_sweep;
    logic           advance;

    logic [IW-1:0]  idx;
    logic [RW-1:0]  burst_row;
    logic [RW-1:0]  wr_row;
    logic [CLW-1:0] wr_col;
    logic           buf_we;
    logic [CW-1:0]  rd_data;
    logic [CW-1:0]  cell_char;

    assign last_cell = (cur_row == RW'(ROWS - 1)) && (cur_col == CLW'(COLS - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_sweep = 1'b0;
        advance     = 1'b0;
        lcd_we      = 1'b0;
        lcd_row     = '0;
        lcd_col     = '0;
        lcd_char    = '0;
        update      = 1'b0;
        ready_o     = 1'b0;
        case (state)
            ST_INIT: begin
                if (!lcd_busy) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                ready_o = !pending;
                if (start_update || pending) begin
                    state_nxt   = ST_WRITE;
                    start_sweep = 1'b1;
                end
            end
            ST_WRITE: begin
                lcd_row  = cur_row;
                lcd_col  = cur_col;
                lcd_char = cell_char;
                if (!lcd_busy) begin
                    lcd_we  = 1'b1;
                    advance = 1'b1;
                    if (last_cell) state_nxt = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                update = 1'b1;
                if (!lcd_busy) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // Requests arriving while a sweep is in flight collapse into one flag.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pending <= 1'b0;
        end else if (start_sweep) begin
            pending <= 1'b0;
        end else if (start_update && (state != ST_IDLE)) begin
            pending <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cur_row <= '0;
            cur_col <= '0;
        end else if (start_sweep) begin
            cur_row <= '0;
            cur_col <= '0;
        end else if (advance) begin
            if (cur_col == CLW'(COLS - 1)) begin
                cur_col <= '0;
                cur_row <= last_cell ? '0 : cur_row + 1'b1;
            end else begin
                cur_col <= cur_col + 1'b1;
            end
        end
    end

    // The burst row is taken live on the first character, latched afterwards.
    assign wr_row = (idx == '0) ? row_sel_i : burst_row;
    assign wr_col = CLW'(idx);
    assign buf_we = valid_i && (idx < IW'(COLS)) && (int'(wr_row) < ROWS);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            idx       <= '0;
            burst_row <= '0;
        end else if (valid_i) begin
            if (idx == '0) burst_row <= row_sel_i;
            if (idx < IW'(COLS)) idx <= idx + 1'b1;
        end else begin
            idx <= '0;
        end
    end

    lcd_char_buf #(
        .ROWS (ROWS),
        .COLS (COLS),
        .CW   (CW),
        .RW   (RW),
        .CLW  (CLW)
    ) u_buf (
        .CLK     (CLK),
        .RST     (RST),
        .we      (buf_we),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (char_i),
        .rd_row  (cur_row),
        .rd_col  (cur_col),
        .rd_data (rd_data)
    );

`ifdef LCD_BLANK_FILL_EN
    logic [IW-1:0] len_q [ROWS];
    logic [IW-1:0] cur_len;

    // A row's length is captured on the cycle its burst ends.
    for (genvar r = 0; r < ROWS; r++) begin : g_len
        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                len_q[r] <= '0;
            end else if (!valid_i && (idx != '0) && (burst_row == RW'(r))) begin
                len_q[r] <= idx;
            end
        end
    end

    always_comb begin
        cur_len = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (cur_row == RW'(r)) cur_len = len_q[r];
        end
    end

    assign cell_char = (IW'(cur_col) >= cur_len) ? CW'(BLANK_CHAR) : rd_data;
`else
    assign cell_char = rd_data;
`endif

endmodule

// File: tb/tb_lcd_line_writer.sv
// Randomised and directed bench for lcd_line_writer: a 16x2 and an 8x1
// instance share stimulus and are compared every cycle with a buffer model.
module tb_lcd_line_writer;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       valid_i = 1'b0;
    logic [7:0] char_i = '0;
    logic [0:0] row_sel_i = '0;
    logic       start_update = 1'b0;
    logic       lcd_busy = 1'b0;

    logic       we0, upd0, rdy0, we1, upd1, rdy1;
    logic [0:0] row0, row1;
    logic [3:0] col0;
    logic [2:0] col1;
    logic [7:0] ch0, ch1;

    always #5 CLK = ~CLK;

    lcd_line_writer dut (
        .CLK(CLK), .RST(RST), .valid_i(valid_i), .char_i(char_i),
        .row_sel_i(row_sel_i), .start_update(start_update), .lcd_busy(lcd_busy),
        .lcd_we(we0), .lcd_row(row0), .lcd_col(col0), .lcd_char(ch0),
        .update(upd0), .ready_o(rdy0)
    );

    lcd_line_writer #(.COLS(8), .ROWS(1)) dut_s (
        .CLK(CLK), .RST(RST), .valid_i(valid_i), .char_i(char_i),
        .row_sel_i(row_sel_i), .start_update(start_update), .lcd_busy(lcd_busy),
        .lcd_we(we1), .lcd_row(row1), .lcd_col(col1), .lcd_char(ch1),
        .update(upd1), .ready_o(rdy1)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Reference model: phase 0 reset/wait, 1 idle, 2 sweeping, 3 finishing.
    int mbuf [2][4][16];
    int mlen [2][4];
    int mph [2];
    int mk [2];
    int mpend [2];
    int midx [2];
    int mbrow [2];

    function automatic int mrows(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int mcols(input int d);
        return (d == 0) ? 16 : 8;
    endfunction

    function automatic logic [31:0] pack(input int we, input int row, input int col,
                                         input int ch, input int upd, input int rdy);
        return 32'(rdy + upd * 2 + we * 4 + ch * 8 + col * 2048 + row * 65536);
    endfunction

    task automatic model_reset(input int d);
        mph[d] = 0; mk[d] = 0; mpend[d] = 0; midx[d] = 0; mbrow[d] = 0;
        for (int r = 0; r < 4; r++) begin
            mlen[d][r] = 0;
            for (int c = 0; c < 16; c++) mbuf[d][r][c] = 32;
        end
    endtask

    function automatic logic [31:0] predict(input int d);
        int r, c, ch;
        r = mk[d] / mcols(d);
        c = mk[d] % mcols(d);
        if (mph[d] == 2) begin
            ch = mbuf[d][r][c];
`ifdef LCD_BLANK_FILL_EN
            if (c >= mlen[d][r]) ch = 32;
`endif
            return pack(lcd_busy ? 0 : 1, r, c, ch, 0, 0);
        end
        if (mph[d] == 3) return pack(0, 0, 0, 0, 1, 0);
        if (mph[d] == 1) return pack(0, 0, 0, 0, 0, (mpend[d] != 0) ? 0 : 1);
        return 32'd0;
    endfunction

    task automatic model_step(input int d);
        int nr, nc, r;
        nr = mrows(d);
        nc = mcols(d);
        case (mph[d])
            0: begin
                if (start_update) mpend[d] = 1;
                if (!lcd_busy) mph[d] = 1;
            end
            1: begin
                if (start_update || mpend[d] != 0) begin
                    mph[d] = 2; mk[d] = 0; mpend[d] = 0;
                end
            end
            2: begin
                if (start_update) mpend[d] = 1;
                if (!lcd_busy) begin
                    mk[d]++;
                    if (mk[d] == nr * nc) begin
                        mph[d] = 3; mk[d] = 0;
                    end
                end
            end
            default: begin
                if (start_update) mpend[d] = 1;
                if (!lcd_busy) mph[d] = 1;
            end
        endcase
        if (valid_i) begin
            r = (midx[d] == 0) ? int'(row_sel_i) : mbrow[d];
            if (midx[d] == 0) mbrow[d] = int'(row_sel_i);
            if (midx[d] < nc) begin
                if (r < nr) mbuf[d][r][midx[d]] = int'(char_i);
                midx[d]++;
            end
        end else begin
            if (midx[d] != 0 && mbrow[d] < nr) mlen[d][mbrow[d]] = midx[d];
            midx[d] = 0;
        end
    endtask

    int we_cnt0, we_cnt1, srow_bad, nonblank;
    int cap [32];
    int ncap;

    task automatic cyc(input bit v, input int ch, input bit rs, input bit st, input bit bz);
        @(negedge CLK);
        valid_i = v;
        char_i = 8'(ch);
        row_sel_i = rs;
        start_update = st;
        lcd_busy = bz;
        #1;
        chk("out_16x2", pack(int'(we0), int'(row0), int'(col0), int'(ch0), int'(upd0), int'(rdy0)), predict(0));
        chk("out_8x1", pack(int'(we1), int'(row1), int'(col1), int'(ch1), int'(upd1), int'(rdy1)), predict(1));
        if (we0) begin
            we_cnt0++;
            if (ncap < 32) cap[ncap] = int'(ch0);
            ncap++;
            if (ch0 != 8'h20) nonblank++;
        end
        if (we1) begin
            we_cnt1++;
            if (row1 != 1'b0) srow_bad++;
        end
        @(posedge CLK);
        if (RST) begin
            model_step(0);
            model_step(1);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic clear_counts();
        we_cnt0 = 0; we_cnt1 = 0; ncap = 0; nonblank = 0;
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RST = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        chk("rst_out_16x2", pack(int'(we0), int'(row0), int'(col0), int'(ch0), int'(upd0), int'(rdy0)), 32'd0);
        chk("rst_out_8x1", pack(int'(we1), int'(row1), int'(col1), int'(ch1), int'(upd1), int'(rdy1)), 32'd0);
        idle_cycles(2);
        #1 RST = 1'b1;
    endtask

    task automatic run_to_cell(input int k);
        bit found;
        found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            if (mph[0] == 2 && mk[0] == k) found = 1;
            else cyc(0, 0, 0, 0, 0);
        end
        if (!found) chk("reach_cell", 32'd0, 32'd1);
    endtask

    initial begin
        string hello;
        hello = "HELLO";
        model_reset(0);
        model_reset(1);
        clear_counts();
        srow_bad = 0;

        idle_cycles(2);
        #1 RST = 1'b1;
        idle_cycles(2);

        // Load "HELLO" to row 0 and sweep.
        for (int i = 0; i < 5; i++) cyc(1, int'(hello[i]), 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        clear_counts();
        idle_cycles(40);
        chk("hello_we_16x2", 32'(we_cnt0), 32'd32);
        chk("hello_we_8x1", 32'(we_cnt1), 32'd8);
        chk("hello_c0", 32'(cap[0]), 32'h48);
        chk("hello_c4", 32'(cap[4]), 32'h4F);
        chk("hello_c5", 32'(cap[5]), 32'h20);

        // 20 characters to row 1: only the first 16 land.
        for (int i = 0; i < 20; i++) cyc(1, 8'h41 + i, (i == 0) ? 1'b1 : 1'b0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        clear_counts();
        idle_cycles(40);
        chk("row1_c0", 32'(cap[16]), 32'h41);
        chk("row1_c15", 32'(cap[31]), 32'h50);

        // Busy stall at cell (0,7).
        cyc(0, 0, 0, 1, 0);
        clear_counts();
        run_to_cell(7);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 1);
            #1;
            chk("busy_hold", {27'd0, we0, col0}, 32'h7);
        end
        idle_cycles(40);
        chk("busy_we_16x2", 32'(we_cnt0), 32'd32);
        chk("busy_cap7", 32'(cap[7]), 32'(mbuf[0][0][7]));

        // Two requests during a sweep collapse into one extra sweep.
        cyc(0, 0, 0, 1, 0);
        clear_counts();
        for (int i = 0; i < 100; i++) cyc(0, 0, 0, (i == 3 || i == 6) ? 1'b1 : 1'b0, 0);
        chk("dbl_we_16x2", 32'(we_cnt0), 32'd64);
        chk("dbl_we_8x1", 32'(we_cnt1), 32'd16);
        chk("dbl_ready", {31'd0, rdy0}, 32'd1);

        // Reset in the middle of a sweep at cell (1,3).
        cyc(0, 0, 0, 1, 0);
        run_to_cell(19);
        apply_reset();
        idle_cycles(3);
        cyc(0, 0, 0, 1, 0);
        clear_counts();
        idle_cycles(40);
        chk("post_rst_we", 32'(we_cnt0), 32'd32);
        chk("post_rst_blank", 32'(nonblank), 32'd0);

        // Random traffic with one reset in the middle.
        for (int i = 0; i < 2500; i++) begin
            if (i == 1200) apply_reset();
            cyc($urandom_range(0, 9) < 7, int'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0,
                $urandom_range(0, 3) == 0);
        end
        chk("s_row_zero", 32'(srow_bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
